// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: scancodes, joystick bit layout and rotation helper for arcade_input_mapper
package arcade_input_pkg;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [8:0] SC_UP    = 9'h175;
  localparam logic [8:0] SC_DOWN  = 9'h172;
  localparam logic [8:0] SC_LEFT  = 9'h16B;
  localparam logic [8:0] SC_RIGHT = 9'h174;
  localparam logic [8:0] SC_SPACE = 9'h029;
  localparam logic [8:0] SC_LCTRL = 9'h014;
  localparam logic [8:0] SC_F1    = 9'h005;
  localparam logic [8:0] SC_5     = 9'h02E;
  localparam logic [8:0] SC_R     = 9'h02D;
  localparam logic [8:0] SC_F     = 9'h02B;
  localparam logic [8:0] SC_D     = 9'h023;
  localparam logic [8:0] SC_G     = 9'h034;
  localparam logic [8:0] SC_A     = 9'h01C;
  localparam logic [8:0] SC_F2    = 9'h006;
  localparam logic [8:0] SC_6     = 9'h036;
  localparam int JB_R     = 0;
  localparam int JB_L     = 1;
  localparam int JB_D     = 2;
  localparam int JB_U     = 3;
  localparam int JB_FIRE  = 4;
  localparam int JB_START = 5;
  localparam int JB_COIN  = 6;
  typedef enum logic [1:0] {ROT_NONE, ROT_CW, ROT_CCW, ROT_180} rot_t;
  // d and the result are both ordered {up, down, left, right}
  function automatic logic [3:0] rotate_dirs(rot_t r, logic [3:0] d);
    return r == ROT_CW  ? {d[1], d[0], d[2], d[3]} :
           r == ROT_CCW ? {d[0], d[1], d[3], d[2]} :
           r == ROT_180 ? {d[2], d[3], d[0], d[1]} : d;
  endfunction
endpackage

// File: rtl/arcade_input_mapper_coin_pulse.sv
// coin_pulse: fixed-length coin pulse started by a rising edge of the request
module coin_pulse
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE_CYCLES = 600000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  output logic coin
);
  localparam int W = COIN_PULSE_CYCLES > 1 ? $clog2(COIN_PULSE_CYCLES) : 1;
  logic [W-1:0] cnt_q;
  logic arm_q;
  // arm_q clears on reset so a request already held at release cannot fire
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      arm_q <= 1'b0;
      coin  <= 1'b0;
    end else begin
      arm_q <= ~req;
      if (req && arm_q && !coin) begin
        coin  <= 1'b1;
        cnt_q <= W'(COIN_PULSE_CYCLES - 1);
      end else if (coin) begin
        coin <= |cnt_q;
        if (|cnt_q) cnt_q <= cnt_q - W'(1);
      end
    end
  end
endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: ps2 key latches + joysticks -> rotated, autofired, coin-pulsed player controls
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS       = 2,
  parameter int COIN_PULSE_CYCLES = 600000,
  parameter int AUTOFIRE_DIV      = 200000
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [64:0]               ps2_key,
  input  logic [16*NUM_PLAYERS-1:0] joystick,
  input  logic                      joy_merge,
  input  logic [1:0]                rotate,
  input  logic [NUM_PLAYERS-1:0]    autofire_en,
  input  logic                      coin_on_start,
  output logic [NUM_PLAYERS-1:0]    up,
  output logic [NUM_PLAYERS-1:0]    down,
  output logic [NUM_PLAYERS-1:0]    left,
  output logic [NUM_PLAYERS-1:0]    right,
  output logic [NUM_PLAYERS-1:0]    fire,
  output logic [NUM_PLAYERS-1:0]    start,
  output logic [NUM_PLAYERS-1:0]    coin
);
  localparam int AW = AUTOFIRE_DIV > 1 ? $clog2(AUTOFIRE_DIV) : 1;
  logic ps2_tog_q, phase_q, fire_alt_q, pressed, ev;
  logic [8:0] code;
  logic [6:0] key0_q, key1_q, joy_all;
  logic [8:0] joy_unused;
  logic [AW-1:0] af_cnt_q;
  logic [NUM_PLAYERS-1:0] up_d, down_d, left_d, right_d, fire_d, start_d, coin_req;
  assign pressed = ps2_key[15:8] != PS2_BRK;
  assign code = {pressed ? ps2_key[15:8] == PS2_EXT : ps2_key[23:16] == PS2_EXT, ps2_key[7:0]};
  // multi-byte PrtScr/Pause sequences carry data above byte 2 and are dropped
  assign ev = ps2_key[64] != ps2_tog_q && ps2_key[63:24] == '0;
  always_comb begin
    joy_all = '0;
    joy_unused = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      joy_all |= joystick[16*i +: 7];
      joy_unused ^= joystick[16*i+7 +: 9];
    end
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_tog_q  <= 1'b0;
      key0_q     <= '0;
      key1_q     <= '0;
      fire_alt_q <= 1'b0;
    end else begin
      ps2_tog_q <= ps2_key[64];
      if (ev) begin
        case (code)
          SC_UP:    key0_q[JB_U]     <= pressed;
          SC_DOWN:  key0_q[JB_D]     <= pressed;
          SC_LEFT:  key0_q[JB_L]     <= pressed;
          SC_RIGHT: key0_q[JB_R]     <= pressed;
          SC_SPACE: key0_q[JB_FIRE]  <= pressed;
          SC_LCTRL: fire_alt_q       <= pressed;
          SC_F1:    key0_q[JB_START] <= pressed;
          SC_5:     key0_q[JB_COIN]  <= pressed;
          SC_R:     key1_q[JB_U]     <= pressed;
          SC_F:     key1_q[JB_D]     <= pressed;
          SC_D:     key1_q[JB_L]     <= pressed;
          SC_G:     key1_q[JB_R]     <= pressed;
          SC_A:     key1_q[JB_FIRE]  <= pressed;
          SC_F2:    key1_q[JB_START] <= pressed;
          SC_6:     key1_q[JB_COIN]  <= pressed;
          default: ;
        endcase
      end
    end
  end
  // phase starts high so the first autofire shot is immediate
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt_q <= '0;
      phase_q  <= 1'b1;
    end else if (af_cnt_q == AW'(AUTOFIRE_DIV - 1)) begin
      af_cnt_q <= '0;
      phase_q  <= ~phase_q;
    end else begin
      af_cnt_q <= af_cnt_q + AW'(1);
    end
  end
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pl
    logic [6:0] joy, raw;
    assign joy = joy_merge ? (g == 0 ? joy_all : joystick[6:0]) : joystick[16*g +: 7];
    assign raw = joy | (g == 0 ? key0_q | {2'b0, fire_alt_q, 4'b0} : g == 1 ? key1_q : 7'b0);
    assign {up_d[g], down_d[g], left_d[g], right_d[g]} = rotate_dirs(rot_t'(rotate), raw[3:0]);
    assign fire_d[g] = raw[JB_FIRE] & (autofire_en[g] ? phase_q : 1'b1);
    assign start_d[g] = raw[JB_START];
    assign coin_req[g] = raw[JB_COIN] | (coin_on_start & raw[JB_START]);
    coin_pulse #(.COIN_PULSE_CYCLES(COIN_PULSE_CYCLES)) u_coin (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .req(coin_req[g]),
      .coin(coin[g])
    );
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      {up, down, left, right, fire, start} <= '0;
    end else begin
      {up, down, left, right, fire, start} <= {up_d, down_d, left_d, right_d, fire_d, start_d};
    end
  end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed checks of key latching, rotation, merge, coin pulses, autofire and reset
module tb_arcade_input_mapper;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic [64:0] ps2_key = '0;
  logic [31:0] joystick = '0;
  logic joy_merge = 1'b0;
  logic coin_on_start = 1'b0;
  logic [1:0] rotate = '0;
  logic [1:0] autofire_en = '0;
  logic [1:0] up, down, left, right, fire, start, coin;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk_sys = ~clk_sys;
  arcade_input_mapper #(.NUM_PLAYERS(2), .COIN_PULSE_CYCLES(8), .AUTOFIRE_DIV(4)) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ps2_key(ps2_key),
    .joystick(joystick),
    .joy_merge(joy_merge),
    .rotate(rotate),
    .autofire_en(autofire_en),
    .coin_on_start(coin_on_start),
    .up(up),
    .down(down),
    .left(left),
    .right(right),
    .fire(fire),
    .start(start),
    .coin(coin)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask
  task automatic send_key(input logic [23:0] b);
    ps2_key = {~ps2_key[64], 40'h0, b};
  endtask
  initial begin
    step(2);
    check("rst_outputs", {up, down, left, right, fire, start, coin}, 16'h0);
    reset_n = 1'b1;
    step(2);
    send_key(24'h00E075);
    step(1);
    check("up_press_lat1", up[0], 1'b0);
    step(1);
    check("up_press_lat2", up[0], 1'b1);
    send_key(24'hE0F075);
    step(1);
    check("up_rel_lat1", up[0], 1'b1);
    step(1);
    check("up_rel_lat2", up[0], 1'b0);
    ps2_key = {~ps2_key[64], 40'h1, 24'h00E075};
    step(2);
    check("long_seq_ignored", up[0], 1'b0);
    send_key(24'h00002D);
    step(2);
    check("p1_r_up", up, 2'b10);
    send_key(24'h00F02D);
    step(2);
    check("p1_r_rel", up, 2'b00);
    send_key(24'h000029);
    step(2);
    check("fire_space", fire, 2'b01);
    send_key(24'h000014);
    step(2);
    send_key(24'h00F029);
    step(2);
    check("fire_ctrl_held", fire, 2'b01);
    send_key(24'h00F014);
    step(2);
    check("fire_all_rel", fire, 2'b00);
    rotate = 2'd1;
    joystick = 32'h0000_0008;
    step(1);
    check("cw_right", right[0], 1'b1);
    check("cw_up", up[0], 1'b0);
    rotate = 2'd3;
    step(1);
    check("r180_down", down[0], 1'b1);
    check("r180_right", right[0], 1'b0);
    rotate = 2'd2;
    step(1);
    check("ccw_left", {up[0], down[0], left[0], right[0]}, 4'b0010);
    rotate = 2'd0;
    joy_merge = 1'b1;
    joystick = 32'h0001_0000;
    step(1);
    check("merge_p0", right, 2'b01);
    joystick = 32'h0001_0001;
    step(1);
    check("merge_p1_j0", right, 2'b11);
    joy_merge = 1'b0;
    joystick = 32'h0001_0000;
    step(1);
    check("nomerge", right, 2'b10);
    joystick = '0;
    step(2);
    joystick = 32'h0000_0040;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check($sformatf("coin_a%0d", i), coin[0], 1'(i < 8));
    end
    joystick = '0;
    step(2);
    joystick = 32'h0000_0040;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check($sformatf("coin_b%0d", i), coin[0], 1'(i < 8));
    end
    joystick = '0;
    coin_on_start = 1'b1;
    send_key(24'h000006);
    step(1);
    check("cos_lat1", {start[1], coin[1]}, 2'b00);
    step(1);
    check("cos_lat2", {start[1], coin[1]}, 2'b11);
    send_key(24'h00F006);
    coin_on_start = 1'b0;
    step(10);
    check("cos_done", coin, 2'b00);
    reset_n = 1'b0;
    joystick = 32'h0010_0000;
    autofire_en = 2'b10;
    step(1);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check($sformatf("af%0d", i), fire[1], 1'((i / 4) % 2 == 0));
    end
    autofire_en = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check($sformatf("af_off%0d", i), fire[1], 1'b1);
    end
    joystick = '0;
    step(1);
    send_key(24'h00E075);
    step(2);
    if (ps2_key[64]) begin
      send_key(24'h00E075);
      step(2);
    end
    check("rst_pre_up", up[0], 1'b1);
    joystick = 32'h0000_0041;
    step(1);
    check("rst_pre_coin", {coin[0], right[0]}, 2'b11);
    step(2);
    reset_n = 1'b0;
    #1;
    check("rst_async", {up, down, left, right, fire, start, coin}, 16'h0);
    step(1);
    reset_n = 1'b1;
    step(1);
    check("rst_rel_joy", right[0], 1'b1);
    check("rst_rel_key", up[0], 1'b0);
    check("rst_rel_coin", coin[0], 1'b0);
    step(3);
    check("rst_held_coin", {coin[0], up[0]}, 2'b00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
